display_scheduler: RTL and testbench

//  Shares the 4-digit seven-segment display between NREQ requesters, each offering an 8-bit unsigned value.

---
 rtl/display_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_display_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// Round-robin owner of a 4-digit seven-segment display: serial binary-to-BCD of the owner's value, then continuous digit scan.
// Conversion latency: grant 1 cycle after req, digits committed 10 cycles after req; the scan itself never stalls.
module display_scheduler #(
  parameter int NREQ  = 2,
  parameter int DIV   = 1025,
  parameter int DWELL = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] val,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic [6:0]        led,
  output logic              d1,
  output logic              d2,
  output logic              d3,
  output logic              d4
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LW = (NREQ > 2) ? 2 : 1;
  localparam int FW = $clog2(DWELL + 1);
  localparam logic [PW-1:0] PMAX     = PW'(DIV - 1);
  localparam logic [LW-1:0] LAST_RST = LW'(NREQ - 1);
  localparam logic [FW-1:0] FMAX     = FW'(DWELL);

  typedef enum logic [1:0] {IDLE, LOAD, CONV, SHOW} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   pcnt;
  logic            tick, frame_end;
  logic [1:0]      slot, slot_n;
  logic [LW-1:0]   last, last_n, pick;
  logic            pick_vld;
  logic [NREQ-1:0] grant_n;
  logic [7:0]      shadow, shadow_n, sh, sh_n, owner_val;
  logic [11:0]     bcd, bcd_n, bcd_adj;
  logic [2:0]      bcnt, bcnt_n;
  logic            busy_n;
  logic [FW-1:0]   fcnt, fcnt_n;
  logic [3:0]      dig_h, dig_t, dig_o, dig_h_n, dig_t_n, dig_o_n;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1011000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign tick      = (pcnt == PMAX);
  assign slot_n    = slot + 2'd1;
  assign frame_end = tick && (slot == 2'd3);
  assign d1        = 1'b1;
  assign owner_val = val[8*int'(last) +: 8];

  // Prescaler and digit scan run free of the arbitration FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      slot <= 2'd0;
      led  <= 7'h7F;
      d2   <= 1'b1;
      d3   <= 1'b1;
      d4   <= 1'b1;
    end else begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
      if (tick) begin
        slot <= slot_n;
        case (slot_n)
          2'd0: begin led <= 7'h7F;       d2 <= 1'b1; d3 <= 1'b1; d4 <= 1'b1; end
          2'd1: begin led <= seg7(dig_h); d2 <= 1'b0; d3 <= 1'b1; d4 <= 1'b1; end
          2'd2: begin led <= seg7(dig_t); d2 <= 1'b1; d3 <= 1'b0; d4 <= 1'b1; end
          2'd3: begin led <= seg7(dig_o); d2 <= 1'b1; d3 <= 1'b1; d4 <= 1'b0; end
        endcase
      end
    end
  end

  // Round-robin search starting just after the previous owner.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick     = LW'(idx);
      end
    end
  end

  // Add-3 on every nibble of 5 or more before each shift.
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      bcd_adj[4*n +: 4] = (bcd[4*n +: 4] >= 4'd5) ? bcd[4*n +: 4] + 4'd3 : bcd[4*n +: 4];
    end
  end

  always_comb begin
    state_n  = state;
    grant_n  = grant;
    last_n   = last;
    shadow_n = shadow;
    sh_n     = sh;
    bcd_n    = bcd;
    bcnt_n   = bcnt;
    busy_n   = busy;
    fcnt_n   = fcnt;
    dig_h_n  = dig_h;
    dig_t_n  = dig_t;
    dig_o_n  = dig_o;
    case (state)
      IDLE: begin
        grant_n = '0;
        if (pick_vld) begin
          grant_n = NREQ'(1) << pick;
          last_n  = pick;
          state_n = LOAD;
        end
      end
      LOAD: begin
        shadow_n = owner_val;
        sh_n     = owner_val;
        bcd_n    = '0;
        bcnt_n   = 3'd0;
        busy_n   = 1'b1;
        state_n  = CONV;
      end
      CONV: begin
        bcd_n  = {bcd_adj[10:0], sh[7]};
        sh_n   = {sh[6:0], 1'b0};
        bcnt_n = bcnt + 3'd1;
        if (bcnt == 3'd7) begin
          dig_h_n = bcd_n[11:8];
          dig_t_n = bcd_n[7:4];
          dig_o_n = bcd_n[3:0];
          busy_n  = 1'b0;
          fcnt_n  = '0;
          state_n = SHOW;
        end
      end
      SHOW: begin
        if (!(|(req & grant))) begin
          grant_n = '0;
          state_n = IDLE;
        end else if ((fcnt >= FMAX) && |(req & ~grant)) begin
          grant_n = '0;
          state_n = IDLE;
        end else if (owner_val != shadow) begin
          state_n = LOAD;
        end else if (frame_end && (fcnt < FMAX)) begin
          fcnt_n = fcnt + FW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      last   <= LAST_RST;
      shadow <= '0;
      sh     <= '0;
      bcd    <= '0;
      bcnt   <= 3'd0;
      busy   <= 1'b0;
      fcnt   <= '0;
      dig_h  <= 4'd0;
      dig_t  <= 4'd0;
      dig_o  <= 4'd0;
    end else begin
      state  <= state_n;
      grant  <= grant_n;
      last   <= last_n;
      shadow <= shadow_n;
      sh     <= sh_n;
      bcd    <= bcd_n;
      bcnt   <= bcnt_n;
      busy   <= busy_n;
      fcnt   <= fcnt_n;
      dig_h  <= dig_h_n;
      dig_t  <= dig_t_n;
      dig_o  <= dig_o_n;
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler: stimulus queues expected grants and committed digits,
// monitors pop them on grant changes and conversion ends and watch the digit scan continuously.
module tb_display_scheduler;
  localparam int DIV   = 4;
  localparam int DWELL = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] val;
  logic [1:0]  grant;
  logic        busy;
  logic [6:0]  led;
  logic        d1, d2, d3, d4;

  int tests = 0;
  int fails = 0;
  logic [11:0] exp_conv[$];
  logic [1:0]  exp_grant[$];

  always #5 clk = ~clk;

  display_scheduler #(.NREQ(2), .DIV(DIV), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .val(val), .grant(grant), .busy(busy),
    .led(led), .d1(d1), .d2(d2), .d3(d3), .d4(d4)
  );

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1011000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [11:0] bcd3(input int h, input int t, input int o);
    return {h[3:0], t[3:0], o[3:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_busy(input logic v, input int budget, input string name);
    int n = 0;
    while (busy !== v && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, busy, v);
  endtask

  task automatic wait_grant(input logic [1:0] g, input int budget, input string name);
    int n = 0;
    while (grant !== g && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, grant, g);
  endtask

  // Grant monitor: every change of grant must match the next queued owner.
  logic [1:0] prev_grant = 2'b00;
  always @(negedge clk) begin
    if (grant !== prev_grant) begin
      if (exp_grant.size() == 0) check("grant_unexpected", grant, prev_grant);
      else check("grant_seq", grant, exp_grant.pop_front());
      prev_grant = grant;
    end
  end

  // Display monitor: cur holds the digits the scan must show; a commit swaps them after one tick period.
  logic [11:0] cur = '0, pend = '0;
  int          skip = 0, bcount = 0;
  logic        prev_busy = 1'b0, prev_rst = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      cur = '0; skip = 0; bcount = 0;
      check("reset_led", led, 7'h7F);
      check("reset_anodes", {d1, d2, d3, d4}, 4'hF);
    end else begin
      if (busy) bcount++;
      if (prev_rst && prev_busy && !busy) begin
        check("busy_len", bcount, 8);
        bcount = 0;
        if (exp_conv.size() == 0) begin
          tests++; fails++;
          $display("FAIL commit_unexpected: commit with nothing expected at %0t", $time);
          pend = cur;
        end else pend = exp_conv.pop_front();
        skip = DIV + 1;
      end
      if (skip > 0) begin
        skip--;
        if (skip == 0) cur = pend;
      end else begin
        check("d1_high", d1, 1'b1);
        case ({d2, d3, d4})
          3'b111:  check("blank_led", led, 7'h7F);
          3'b011:  check("hundreds", led, seg(int'(cur[11:8])));
          3'b101:  check("tens", led, seg(int'(cur[7:4])));
          3'b110:  check("ones", led, seg(int'(cur[3:0])));
          default: check("one_anode", {d2, d3, d4}, 3'b111);
        endcase
      end
    end
    prev_busy = busy;
    prev_rst  = rst_n;
  end

  initial begin
    int n;
    int vals[4];
    int exph[4], expt[4], expo[4];
    vals = '{0, 255, 9, 100};
    exph = '{0, 2, 0, 1};
    expt = '{0, 5, 0, 0};
    expo = '{0, 5, 9, 0};
    rst_n = 1'b0; req = 2'b00; val = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_led", led, 7'h7F);
    check("rst_anodes", {d1, d2, d3, d4}, 4'hF);
    rst_n = 1'b1;

    // After release the scan starts at the blank slot and moves to hundreds first.
    n = 0;
    while ({d2, d3, d4} === 3'b111 && n < 3 * DIV) begin
      @(posedge clk); #1;
      n++;
    end
    check("first_slot", {d2, d3, d4}, 3'b011);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midscan_led", led, 7'h7F);
    check("midscan_anodes", {d1, d2, d3, d4}, 4'hF);
    check("midscan_grant", grant, 2'b00);
    check("midscan_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Single requester, value 237, exact latency.
    #1;
    val[7:0] = 8'd237; req = 2'b01;
    exp_grant.push_back(2'b01);
    exp_conv.push_back(bcd3(2, 3, 7));
    @(posedge clk); #1;
    check("lat_grant", grant, 2'b01);
    check("lat_busy_low", busy, 1'b0);
    @(posedge clk); #1;
    check("lat_busy_start", busy, 1'b1);
    repeat (7) begin
      @(posedge clk); #1;
      check("lat_busy_hold", busy, 1'b1);
    end
    @(posedge clk); #1;
    check("lat_busy_end", busy, 1'b0);
    repeat (3 * FRAME) @(posedge clk);

    // Boundary values via value changes in SHOW.
    for (int i = 0; i < 4; i++) begin
      #1;
      val[7:0] = vals[i][7:0];
      exp_conv.push_back(bcd3(exph[i], expt[i], expo[i]));
      repeat (3 * FRAME) @(posedge clk);
    end

    // Value change 42 -> 199: old digits must stay on display until the commit.
    #1;
    val[7:0] = 8'd42;
    exp_conv.push_back(bcd3(0, 4, 2));
    repeat (3 * FRAME) @(posedge clk);
    #1;
    val[7:0] = 8'd199;
    exp_conv.push_back(bcd3(1, 9, 9));
    repeat (3 * FRAME) @(posedge clk);
    check("grant_kept", grant, 2'b01);

    // Owner drops request with nobody else waiting.
    #1;
    req = 2'b00;
    exp_grant.push_back(2'b00);
    repeat (2 * FRAME) @(posedge clk);
    #1;
    check("idle_grant", grant, 2'b00);

    // Round-robin from reset with both requesting.
    rst_n = 1'b0;
    val = {8'd180, 8'd37};
    req = 2'b11;
    exp_grant.push_back(2'b01);
    exp_grant.push_back(2'b00);
    exp_grant.push_back(2'b10);
    exp_grant.push_back(2'b00);
    exp_grant.push_back(2'b01);
    exp_conv.push_back(bcd3(0, 3, 7));
    exp_conv.push_back(bcd3(1, 8, 0));
    exp_conv.push_back(bcd3(0, 3, 7));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_busy(1'b1, 20, "rr_busy_rise");
    wait_busy(1'b0, 20, "rr_busy_fall");
    n = 0;
    while (grant !== 2'b00 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (n < 18 || n > 33) begin
      fails++;
      $display("FAIL dwell: grant held %0d cycles after commit, expected 18..33", n);
    end
    wait_grant(2'b01, 200, "rr_back_to_0");
    wait_busy(1'b1, 20, "rr2_busy_rise");
    wait_busy(1'b0, 20, "rr2_busy_fall");
    req = 2'b00;
    exp_grant.push_back(2'b00);
    repeat (2 * FRAME) @(posedge clk);

    // Async reset during a conversion: digits return to zero, nothing committed.
    #1;
    val[7:0] = 8'd123;
    req = 2'b01;
    exp_grant.push_back(2'b01);
    wait_busy(1'b1, 20, "rc_busy_rise");
    repeat (3) @(posedge clk);
    #1;
    exp_grant.push_back(2'b00);
    req = 2'b00;
    rst_n = 1'b0;
    #1;
    check("rc_busy", busy, 1'b0);
    check("rc_grant", grant, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3 * FRAME) @(posedge clk);
    #1;

    check("conv_queue_empty", exp_conv.size(), 0);
    check("grant_queue_empty", exp_grant.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
